mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
- Multi-cycle bus sequencer between the MEM stage and the shared RAM1/UART data bus; replaces the purely combinational strobe generation in the MEM stage.
- Accepts one load/store request at a time and generates glitch-free registered RAM1 and UART strobes.
- Holds the pipeline through the scheduler pause request until the access completes, then returns read data with a one-cycle done pulse.

Parameters:
- RAM_RD_CYCLES, 2, cycles OE is held low before read data is captured (1..15).
- RAM_WR_CYCLES, 1, cycles WE is held low (1..15).
- UART_BASE, 16'hBF00, UART data register address; UART_BASE+1 is the status register.
- UART_TIMEOUT, 16'h0400, maximum cycles to wait for the UART transmitter after a write.

Ports:
- mci_clk  in  1  pipeline clock.
- mci_rst  in  1  synchronous reset, active-high.
- mci_req  in  1  MEM stage requests an access; held stable until mco_done.
- mci_we  in  1  1 = store, 0 = load.
- mci_addr  in  16  word address.
- mci_wdata  in  16  store data.
- mco_rdata  out  16  load result; valid while mco_done = 1 and held until the next access.
- mco_done  out  1  one-cycle completion pulse.
- mco_busy  out  1  pause request to the scheduler; equals mci_req & ~mco_done & ~mci_rst (combinational).
- mco_ram1_en  out  1  RAM1 chip enable, active-low.
- mco_ram1_we  out  1  RAM1 write enable, active-low.
- mco_ram1_oe  out  1  RAM1 output enable, active-low.
- mco_ram1_addr  out  16  RAM1 address.
- mcio_ram1_data  inout  16  shared RAM1/UART data bus.
- mci_uart_tbre  in  1  UART transmit buffer empty.
- mci_uart_tsre  in  1  UART transmit shift register empty.
- mci_uart_data_ready  in  1  UART receive byte available.
- mco_uart_wrn  out  1  UART write strobe, active-low.
- mco_uart_rdn  out  1  UART read strobe, active-low.

Behaviour:
- Reset, effective at the next edge, including mid-access:
  - state = IDLE.
  - mco_ram1_en, mco_ram1_we, mco_ram1_oe, mco_uart_wrn, mco_uart_rdn = 1.
  - mco_ram1_addr = 0, mco_rdata = 0, mco_done = 0.
  - Data bus released to Z.
  - An aborted write is not retried.
- All strobes, the address, the bus drive enable and the drive data are registered; none is decoded combinationally.
- States:
  - IDLE, RAM_RD, RAM_WR_SETUP, RAM_WR_PULSE, RAM_WR_HOLD.
  - UART_RD, UART_WR_PULSE, UART_WR_WAIT, STAT_RD, NOP, DONE.
- IDLE:
  - On an edge with mci_req = 1, latch addr/we/wdata, load the wait counter and decode the address.
  - Address == UART_BASE -> UART_RD or UART_WR_PULSE.
  - Address == UART_BASE+1 -> STAT_RD (a write to this address -> NOP).
  - UART_BASE+2 .. UART_BASE+15 -> NOP.
  - Any other address -> RAM_RD or RAM_WR_SETUP.
- RAM_RD:
  - en = 0, oe = 0, bus Z, for RAM_RD_CYCLES cycles.
  - On the last cycle's edge, capture the bus into mco_rdata, then go to DONE.
- RAM write sequence:
  - RAM_WR_SETUP: en = 0, bus driven with wdata, we = 1, for 1 cycle.
  - RAM_WR_PULSE: we = 0 for RAM_WR_CYCLES cycles.
  - RAM_WR_HOLD: we = 1, data still driven, for 1 cycle, then DONE.
- UART accesses keep ram1_en = 1 throughout (bus is shared).
- UART_RD:
  - rdn = 0 for 2 cycles.
  - Capture {8'h00, bus[7:0]} into mco_rdata, then DONE.
  - Proceeds regardless of data_ready; polling is software's job.
- UART write sequence:
  - UART_WR_PULSE: bus driven with {8'h00, wdata[7:0]}, wrn = 0, for 1 cycle.
  - UART_WR_WAIT: wrn = 1, bus Z.
  - Leave UART_WR_WAIT for DONE when tbre & tsre = 1 or the counter reaches UART_TIMEOUT, whichever comes first.
- STAT_RD: mco_rdata = {14'h0, data_ready, tbre & tsre}, sampled at the edge; then DONE.
- NOP: reads return 16'h0000, writes are dropped; 1 cycle, then DONE.
- DONE:
  - mco_done = 1 for exactly one cycle, then IDLE.
  - A request present in DONE is not accepted; the earliest next accept is the first IDLE edge.
- Latency in edges after the accept edge until mco_done rises:
  - RAM read: RAM_RD_CYCLES + 1.
  - RAM write: RAM_WR_CYCLES + 3.
  - Status read or NOP: 2.
  - UART read: 3.
  - UART write: 3 + wait cycles.
- Bus contention rule: the bus is driven only in RAM_WR_SETUP, RAM_WR_PULSE, RAM_WR_HOLD and UART_WR_PULSE. oe, rdn and the drive enable are never active in the same cycle.

Decomposition:
- Shared header mem_bus_defs.vh holds:
  - the state encodings;
  - UART_DATA_OFS = 0, UART_STAT_OFS = 1;
  - status bit positions: bit 0 = tx ready, bit 1 = rx ready.
- One sub-module, mbc_wait_counter: 16-bit loadable down-counter with a zero flag, shared by all timed states.

Test Plan:
- RAM read, RAM_RD_CYCLES = 2: req addr 16'h4000, RAM model returns 16'hBEEF -> oe low for exactly 2 cycles, mco_rdata = 16'hBEEF, done rises at edge 3, busy low afterwards.
- RAM write of 16'h1234 to 16'h4002 -> en = 0 throughout; we low exactly 1 cycle with addr and data stable 1 cycle before and 1 cycle after; done rises at edge 4; read-back returns 16'h1234.
- UART write 16'hAB41 to 16'hBF00, tsre held low for 5 cycles -> wrn low exactly 1 cycle with bus = 16'h0041, ram1_en = 1 throughout; done rises 1 cycle after tbre & tsre = 1.
- Status read of 16'hBF01 with data_ready = 1, tbre = tsre = 1 -> mco_rdata = 16'h0003; again with data_ready = 0, tsre = 0 -> 16'h0000.
- UART write timeout, UART_TIMEOUT = 8, tbre stuck at 0 -> done rises after 8 wait cycles; the next request (RAM read) completes normally.
- mci_rst pulsed during RAM_WR_PULSE -> next edge: we = 1, en = 1, bus Z, done = 0, state IDLE; a new request is accepted on the first edge after reset drops.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the MEM-stage bus sequencer: states, UART register map, status layout.
package mem_bus_ctrl_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CNT_W  = 16;

  // UART register offsets relative to UART_BASE and size of the decoded UART window
  localparam logic [ADDR_W-1:0] UART_DATA_OFS = 16'd0;
  localparam logic [ADDR_W-1:0] UART_STAT_OFS = 16'd1;
  localparam logic [ADDR_W-1:0] UART_WIN_SIZE = 16'd16;

  // Status register bit positions
  localparam int unsigned STAT_TX_RDY_BIT = 0;
  localparam int unsigned STAT_RX_RDY_BIT = 1;

  typedef enum logic [3:0] {
    ST_IDLE          = 4'd0,
    ST_RAM_RD        = 4'd1,
    ST_RAM_WR_SETUP  = 4'd2,
    ST_RAM_WR_PULSE  = 4'd3,
    ST_RAM_WR_HOLD   = 4'd4,
    ST_UART_RD       = 4'd5,
    ST_UART_WR_PULSE = 4'd6,
    ST_UART_WR_WAIT  = 4'd7,
    ST_STAT_RD       = 4'd8,
    ST_NOP           = 4'd9,
    ST_DONE          = 4'd10
  } mbc_state_e;

  typedef enum logic [1:0] {
    TGT_RAM       = 2'd0,
    TGT_UART_DATA = 2'd1,
    TGT_UART_STAT = 2'd2,
    TGT_NOP       = 2'd3
  } mbc_target_e;

  // Classify a word address against the UART window starting at base
  function automatic mbc_target_e decode_target(input logic [ADDR_W-1:0] addr,
                                                input logic [ADDR_W-1:0] base);
    logic [ADDR_W-1:0] ofs;
    ofs = addr - base;
    if (ofs == UART_DATA_OFS)      return TGT_UART_DATA;
    else if (ofs == UART_STAT_OFS) return TGT_UART_STAT;
    else if (ofs < UART_WIN_SIZE)  return TGT_NOP;
    else                           return TGT_RAM;
  endfunction

  // Assemble the UART status word
  function automatic logic [DATA_W-1:0] status_word(input logic rx_rdy, input logic tx_rdy);
    logic [DATA_W-1:0] w;
    w                  = '0;
    w[STAT_TX_RDY_BIT] = tx_rdy;
    w[STAT_RX_RDY_BIT] = rx_rdy;
    return w;
  endfunction

endpackage

// File: rtl/mbc_wait_counter.sv
// Loadable down-counter with zero flag; times every multi-cycle bus phase.
module mbc_wait_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero_c
);

  logic [CNT_W-1:0] r_count;

  // Load has priority; decrement saturates at zero
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Multi-cycle sequencer between the MEM stage and the shared RAM1/UART bus.
// Every strobe, address and bus-drive control is computed for the next state and registered,
// so the pins switch cleanly on the clock edge together with the state.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned       RAM_RD_CYCLES = 2,
  parameter int unsigned       RAM_WR_CYCLES = 1,
  parameter logic [ADDR_W-1:0] UART_BASE     = 16'hBF00,
  parameter logic [CNT_W-1:0]  UART_TIMEOUT  = 16'h0400
) (
  input  logic              mci_clk,
  input  logic              mci_rst,
  input  logic              mci_req,
  input  logic              mci_we,
  input  logic [ADDR_W-1:0] mci_addr,
  input  logic [DATA_W-1:0] mci_wdata,
  output logic [DATA_W-1:0] mco_rdata,
  output logic              mco_done,
  output logic              mco_busy,
  output logic              mco_ram1_en,
  output logic              mco_ram1_we,
  output logic              mco_ram1_oe,
  output logic [ADDR_W-1:0] mco_ram1_addr,
  inout  wire  [DATA_W-1:0] mcio_ram1_data,
  input  logic              mci_uart_tbre,
  input  logic              mci_uart_tsre,
  input  logic              mci_uart_data_ready,
  output logic              mco_uart_wrn,
  output logic              mco_uart_rdn
);

  // Counter preloads: a phase of N cycles loads N-1 and ends on the zero flag
  localparam logic [CNT_W-1:0] RD_LOAD      = CNT_W'(RAM_RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD      = CNT_W'(RAM_WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] UART_RD_LOAD = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO_LOAD     = UART_TIMEOUT - CNT_W'(1);

  mbc_state_e        r_state, w_state_nxt;
  logic              r_en, r_we, r_oe, r_wrn, r_rdn, r_drive, r_done, r_wr;
  logic              w_en_nxt, w_we_nxt, w_oe_nxt, w_wrn_nxt, w_rdn_nxt;
  logic              w_drive_nxt, w_done_nxt, w_wr_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_dout, w_dout_nxt;
  logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
  logic              w_cnt_load, w_cnt_dec, w_cnt_zero;
  logic [CNT_W-1:0]  w_cnt_val;
  logic              w_tx_rdy;
  mbc_target_e       w_target;

  assign w_tx_rdy = mci_uart_tbre & mci_uart_tsre;
  assign w_target = decode_target(mci_addr, UART_BASE);

  mbc_wait_counter #(
    .CNT_W (CNT_W)
  ) u_wait_cnt (
    .i_clk      (mci_clk),
    .i_rst      (mci_rst),
    .i_load     (w_cnt_load),
    .i_dec      (w_cnt_dec),
    .i_load_val (w_cnt_val),
    .o_zero_c   (w_cnt_zero)
  );

  // State register
  always_ff @(posedge mci_clk) begin
    if (mci_rst) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Registered strobes, address, drive data and read data
  always_ff @(posedge mci_clk) begin
    if (mci_rst) begin
      r_en    <= 1'b1;
      r_we    <= 1'b1;
      r_oe    <= 1'b1;
      r_wrn   <= 1'b1;
      r_rdn   <= 1'b1;
      r_drive <= 1'b0;
      r_done  <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_dout  <= '0;
      r_rdata <= '0;
    end else begin
      r_en    <= w_en_nxt;
      r_we    <= w_we_nxt;
      r_oe    <= w_oe_nxt;
      r_wrn   <= w_wrn_nxt;
      r_rdn   <= w_rdn_nxt;
      r_drive <= w_drive_nxt;
      r_done  <= w_done_nxt;
      r_wr    <= w_wr_nxt;
      r_addr  <= w_addr_nxt;
      r_dout  <= w_dout_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

  // Next state plus the strobe values that belong to that next state
  always_comb begin
    w_state_nxt = r_state;
    w_en_nxt    = 1'b1;
    w_we_nxt    = 1'b1;
    w_oe_nxt    = 1'b1;
    w_wrn_nxt   = 1'b1;
    w_rdn_nxt   = 1'b1;
    w_drive_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_wr_nxt    = r_wr;
    w_addr_nxt  = r_addr;
    w_dout_nxt  = r_dout;
    w_rdata_nxt = r_rdata;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    w_cnt_val   = '0;

    case (r_state)
      ST_IDLE: begin
        if (mci_req) begin
          w_addr_nxt = mci_addr;
          w_wr_nxt   = mci_we;
          w_dout_nxt = mci_wdata;
          case (w_target)
            TGT_UART_DATA: begin
              if (mci_we) begin
                w_state_nxt = ST_UART_WR_PULSE;
                w_wrn_nxt   = 1'b0;
                w_drive_nxt = 1'b1;
                w_dout_nxt  = {8'h00, mci_wdata[7:0]};
              end else begin
                w_state_nxt = ST_UART_RD;
                w_rdn_nxt   = 1'b0;
                w_cnt_load  = 1'b1;
                w_cnt_val   = UART_RD_LOAD;
              end
            end
            TGT_UART_STAT: w_state_nxt = mci_we ? ST_NOP : ST_STAT_RD;
            TGT_NOP:       w_state_nxt = ST_NOP;
            default: begin
              w_en_nxt = 1'b0;
              if (mci_we) begin
                w_state_nxt = ST_RAM_WR_SETUP;
                w_drive_nxt = 1'b1;
              end else begin
                w_state_nxt = ST_RAM_RD;
                w_oe_nxt    = 1'b0;
                w_cnt_load  = 1'b1;
                w_cnt_val   = RD_LOAD;
              end
            end
          endcase
        end
      end

      ST_RAM_RD: begin
        if (w_cnt_zero) begin
          w_rdata_nxt = mcio_ram1_data;
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_en_nxt  = 1'b0;
          w_oe_nxt  = 1'b0;
          w_cnt_dec = 1'b1;
        end
      end

      ST_RAM_WR_SETUP: begin
        w_state_nxt = ST_RAM_WR_PULSE;
        w_en_nxt    = 1'b0;
        w_we_nxt    = 1'b0;
        w_drive_nxt = 1'b1;
        w_cnt_load  = 1'b1;
        w_cnt_val   = WR_LOAD;
      end

      ST_RAM_WR_PULSE: begin
        w_en_nxt    = 1'b0;
        w_drive_nxt = 1'b1;
        if (w_cnt_zero) begin
          w_state_nxt = ST_RAM_WR_HOLD;
        end else begin
          w_we_nxt  = 1'b0;
          w_cnt_dec = 1'b1;
        end
      end

      ST_RAM_WR_HOLD: begin
        w_state_nxt = ST_DONE;
        w_done_nxt  = 1'b1;
      end

      ST_UART_RD: begin
        if (w_cnt_zero) begin
          w_rdata_nxt = {8'h00, mcio_ram1_data[7:0]};
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_rdn_nxt = 1'b0;
          w_cnt_dec = 1'b1;
        end
      end

      ST_UART_WR_PULSE: begin
        w_state_nxt = ST_UART_WR_WAIT;
        w_cnt_load  = 1'b1;
        w_cnt_val   = TMO_LOAD;
      end

      // Wait for the transmitter to drain, bounded by the timeout
      ST_UART_WR_WAIT: begin
        if (w_tx_rdy || w_cnt_zero) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end

      ST_STAT_RD: begin
        w_rdata_nxt = status_word(mci_uart_data_ready, w_tx_rdy);
        w_state_nxt = ST_DONE;
        w_done_nxt  = 1'b1;
      end

      ST_NOP: begin
        if (!r_wr) w_rdata_nxt = '0;
        w_state_nxt = ST_DONE;
        w_done_nxt  = 1'b1;
      end

      ST_DONE:  w_state_nxt = ST_IDLE;

      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign mco_rdata      = r_rdata;
  assign mco_done       = r_done;
  assign mco_busy       = mci_req & ~r_done & ~mci_rst;
  assign mco_ram1_en    = r_en;
  assign mco_ram1_we    = r_we;
  assign mco_ram1_oe    = r_oe;
  assign mco_ram1_addr  = r_addr;
  assign mco_uart_wrn   = r_wrn;
  assign mco_uart_rdn   = r_rdn;
  assign mcio_ram1_data = r_drive ? r_dout : 16'hzzzz;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with a small RAM1 and UART bus model.
module tb_mem_bus_ctrl;
  import mem_bus_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        done;
  logic        busy;
  logic        ram_en, ram_we, ram_oe;
  logic [15:0] ram_addr;
  wire  [15:0] bus;
  logic        tbre;
  logic        tsre;
  logic        data_ready;
  logic        uart_wrn, uart_rdn;

  int total = 0;
  int bad   = 0;

  // Bus model state
  logic [15:0]  mem [0:255];
  logic [255:0] mem_vld;
  logic [15:0]  ram_rd_val;
  logic [15:0]  uart_rx_word;
  int           cyc;
  int           tsre_rel;
  logic         tbre_set;

  // Access monitor results
  int          n_edges, n_oe, n_we, n_wrn, n_rdn, n_en_lo, n_en_ok, n_cont;
  logic [15:0] wrn_bus;
  logic [15:0] got_rd;
  logic        got_done;
  logic        busy_at_done;

  mem_bus_ctrl #(
    .RAM_RD_CYCLES (2),
    .RAM_WR_CYCLES (1),
    .UART_BASE     (16'hBF00),
    .UART_TIMEOUT  (16'h0008)
  ) dut (
    .mci_clk             (clk),
    .mci_rst             (rst),
    .mci_req             (req),
    .mci_we              (we),
    .mci_addr            (addr),
    .mci_wdata           (wdata),
    .mco_rdata           (rdata),
    .mco_done            (done),
    .mco_busy            (busy),
    .mco_ram1_en         (ram_en),
    .mco_ram1_we         (ram_we),
    .mco_ram1_oe         (ram_oe),
    .mco_ram1_addr       (ram_addr),
    .mcio_ram1_data      (bus),
    .mci_uart_tbre       (tbre),
    .mci_uart_tsre       (tsre),
    .mci_uart_data_ready (data_ready),
    .mco_uart_wrn        (uart_wrn),
    .mco_uart_rdn        (uart_rdn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM1 model: unwritten words read back as 16'hBEEF ^ low address byte
  always @(posedge clk) begin
    if (rst) mem_vld <= '0;
    else if (!ram_en && !ram_we) begin
      mem[ram_addr[7:0]]     <= bus;
      mem_vld[ram_addr[7:0]] <= 1'b1;
    end
  end

  assign ram_rd_val = mem_vld[ram_addr[7:0]] ? mem[ram_addr[7:0]]
                                             : (16'hBEEF ^ {8'h00, ram_addr[7:0]});
  assign bus  = (!ram_en && !ram_oe) ? ram_rd_val : (!uart_rdn ? uart_rx_word : 16'hzzzz);
  assign tsre = (cyc >= tsre_rel);
  assign tbre = tbre_set;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Raise a request and watch the pins each cycle until done (bounded)
  task automatic access(input logic a_we, input logic [15:0] a_addr,
                        input logic [15:0] a_wdata, input int tsre_lo);
    @(negedge clk);
    req   = 1'b1;
    we    = a_we;
    addr  = a_addr;
    wdata = a_wdata;
    if (tsre_lo > 0) tsre_rel = cyc + tsre_lo;
    n_edges = 0; n_oe = 0; n_we = 0; n_wrn = 0; n_rdn = 0; n_en_lo = 0; n_en_ok = 0;
    wrn_bus  = 16'h0;
    got_done = 1'b0;
    while (!got_done && n_edges < 40) begin
      @(posedge clk);
      #1;
      n_edges++;
      if (!ram_oe)   n_oe++;
      if (!ram_we)   n_we++;
      if (!uart_rdn) n_rdn++;
      if (!uart_wrn) begin
        n_wrn++;
        wrn_bus = bus;
      end
      if (!ram_en) begin
        n_en_lo++;
        if (bus === a_wdata && ram_addr === a_addr) n_en_ok++;
      end
      if ((!ram_oe || !uart_rdn) && dut.r_drive) n_cont++;
      got_done = done;
    end
    got_rd       = rdata;
    busy_at_done = busy;
    chkb("done_seen", got_done, 1'b1);
  endtask

  task automatic release_req();
    @(negedge clk);
    req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b1; we = 1'b0; addr = 16'h4000; wdata = 16'h0;
    data_ready = 1'b0; tbre_set = 1'b1; tsre_rel = 0; cyc = 0; n_cont = 0;
    uart_rx_word = 16'h5A3C;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_en", ram_en, 1'b1);
    chkb("rst_we", ram_we, 1'b1);
    chkb("rst_oe", ram_oe, 1'b1);
    chkb("rst_wrn", uart_wrn, 1'b1);
    chkb("rst_rdn", uart_rdn, 1'b1);
    chk16("rst_addr", ram_addr, 16'h0000);
    chk16("rst_rdata", rdata, 16'h0000);
    chkb("rst_done", done, 1'b0);
    chkb("rst_drive", dut.r_drive, 1'b0);
    @(negedge clk);
    rst = 1'b0; req = 1'b0;

    // RAM read of an unwritten word
    access(1'b0, 16'h4000, 16'h0000, 0);
    chki("rd_latency", n_edges, 3);
    chki("rd_oe_cycles", n_oe, 2);
    chk16("rd_data", got_rd, 16'hBEEF);
    chkb("rd_busy_at_done", busy_at_done, 1'b0);
    // Request still held through DONE must not be re-accepted
    @(posedge clk);
    #1;
    chkb("done_no_accept_oe", ram_oe, 1'b1);
    chkb("done_no_accept_done", done, 1'b0);
    chkb("idle_busy_req_held", busy, 1'b1);
    release_req();
    #1;
    chkb("idle_busy", busy, 1'b0);

    // RAM write, then read back
    access(1'b1, 16'h4002, 16'h1234, 0);
    release_req();
    chki("wr_latency", n_edges, 4);
    chki("wr_we_cycles", n_we, 1);
    chki("wr_en_cycles", n_en_lo, 3);
    chki("wr_addr_data_stable", n_en_ok, 3);
    access(1'b0, 16'h4002, 16'h0000, 0);
    release_req();
    chk16("wr_readback", got_rd, 16'h1234);
    chki("rdback_latency", n_edges, 3);

    // UART write with tsre low for 5 cycles
    access(1'b1, 16'hBF00, 16'hAB41, 5);
    release_req();
    chki("uwr_latency", n_edges, 6);
    chki("uwr_wrn_cycles", n_wrn, 1);
    chk16("uwr_bus", wrn_bus, 16'h0041);
    chki("uwr_en_low", n_en_lo, 0);

    // Status reads
    data_ready = 1'b1;
    access(1'b0, 16'hBF01, 16'h0000, 0);
    release_req();
    chki("stat_latency", n_edges, 2);
    chk16("stat_all_ready", got_rd, 16'h0003);
    data_ready = 1'b0;
    tsre_rel   = 32'h7FFF_FFFF;
    access(1'b0, 16'hBF01, 16'h0000, 0);
    release_req();
    chk16("stat_none_ready", got_rd, 16'h0000);
    tsre_rel = 0;

    // UART read keeps only the low byte
    access(1'b0, 16'hBF00, 16'h0000, 0);
    release_req();
    chki("urd_latency", n_edges, 3);
    chki("urd_rdn_cycles", n_rdn, 2);
    chk16("urd_data", got_rd, 16'h003C);

    // Write to status register is dropped; read data is held
    access(1'b1, 16'hBF01, 16'hFFFF, 0);
    release_req();
    chki("nop_wr_latency", n_edges, 2);
    chk16("nop_wr_rdata_held", got_rd, 16'h003C);
    access(1'b0, 16'hBF05, 16'h0000, 0);
    release_req();
    chki("nop_rd_latency", n_edges, 2);
    chk16("nop_rd_data", got_rd, 16'h0000);

    // UART write timeout, then a normal RAM read
    tbre_set = 1'b0;
    access(1'b1, 16'hBF00, 16'h0055, 0);
    release_req();
    chki("tmo_latency", n_edges, 10);
    tbre_set = 1'b1;
    access(1'b0, 16'h4000, 16'h0000, 0);
    release_req();
    chki("post_tmo_latency", n_edges, 3);
    chk16("post_tmo_data", got_rd, 16'hBEEF);
    chki("bus_contention", n_cont, 0);

    // Reset in the middle of a RAM write pulse
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 16'h4010; wdata = 16'h7777;
    @(posedge clk);
    @(posedge clk);
    #1;
    chkb("mid_wr_we_low", ram_we, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chkb("rst_busy_forced", busy, 1'b0);
    @(posedge clk);
    #1;
    chkb("abort_we", ram_we, 1'b1);
    chkb("abort_en", ram_en, 1'b1);
    chkb("abort_done", done, 1'b0);
    chkb("abort_drive", dut.r_drive, 1'b0);
    chki("abort_state", int'(dut.r_state), int'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0; we = 1'b0; addr = 16'hBF01; data_ready = 1'b1;
    @(posedge clk);
    #1;
    chkb("post_rst_e1_done", done, 1'b0);
    chki("post_rst_accept", int'(dut.r_state), int'(ST_STAT_RD));
    @(posedge clk);
    #1;
    chkb("post_rst_e2_done", done, 1'b1);
    chk16("post_rst_rdata", rdata, 16'h0003);
    release_req();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
